// File: rtl/palette_pixel_out.sv
// -----------------------------------------------------------------------------
// palette_pixel_out
//
// Pixel output stage wrapped around a 256x16 palette BRAM. Both BRAM ports
// share the pixel clock.
//
// Read side: the per-pixel 8-bit colour index is sent straight to the
// palette read port. The sync and visible strobes are delayed so that they
// line up with the one-clock BRAM latency. The looked-up colour is then
// registered as 4:4:4 RGB. Index to RGB takes two clocks, and the strobes
// take the same two clocks.
//
// Write side: host palette writes go into a small FIFO. Entries are
// committed to the palette write port only while the generator is outside
// the visible area, so a palette change never tears mid-line. Setting
// WRITE_ANYTIME makes commits ignore visible_i.
//
// Optional feature, macro PAL_BORDER_EN:
//   Adds a 16-bit border colour register. It is loaded by a committed write
//   to palette address 0xFF, which still also updates the BRAM. When the
//   stage-1 pixel is both border and visible, its RGB comes from this
//   register instead of the palette.
//
// Ports:
//   clk               pixel clock, also the palette write clock
//   reset_ni          synchronous reset, active low
//   pix_index_i       colour index of the current pixel
//   visible_i         current pixel is in the active area
//   hsync_i, vsync_i  syncs in generator polarity
//   border_i          pixel is border (only used with PAL_BORDER_EN)
//   pal_rd_en_o       palette read enable
//   pal_rd_addr_o     palette read address
//   pal_rd_data_i     palette read data, valid one clock after the read
//   pal_wr_en_o       palette write enable (one clock per committed entry)
//   pal_wr_addr_o     palette write address
//   pal_wr_data_o     palette write data
//   host_wr_valid_i   host write request
//   host_wr_ready_o   FIFO can accept an entry
//   host_wr_addr_i    palette entry to write
//   host_wr_data_i    colour, 0x0RGB
//   fifo_empty_o      no pending writes
//   red_o, green_o, blue_o        registered colour
//   hsync_o, vsync_o, visible_o   strobes delayed to match the colour
// -----------------------------------------------------------------------------
module palette_pixel_out #(
    parameter int FIFO_DEPTH    = 4,
    parameter int WRITE_ANYTIME = 0
) (
    input  logic        clk,
    input  logic        reset_ni,

    input  logic [7:0]  pix_index_i,
    input  logic        visible_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        border_i,

    output logic        pal_rd_en_o,
    output logic [7:0]  pal_rd_addr_o,
    input  logic [15:0] pal_rd_data_i,

    output logic        pal_wr_en_o,
    output logic [7:0]  pal_wr_addr_o,
    output logic [15:0] pal_wr_data_o,

    input  logic        host_wr_valid_i,
    output logic        host_wr_ready_o,
    input  logic [7:0]  host_wr_addr_i,
    input  logic [15:0] host_wr_data_i,
    output logic        fifo_empty_o,

    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        visible_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Select the 12-bit colour for one pixel. Blanked pixels are forced to
    // black. Bits [15:12] of each 16-bit source are never displayed.
    function automatic logic [11:0] pick_rgb(
        input logic        vld,
        input logic        use_border,
        input logic [15:0] pal_colour,
        input logic [15:0] border_colour
    );
        if (!vld)
            return 12'h000;
        else if (use_border)
            return border_colour[11:0];
        else
            return pal_colour[11:0];
    endfunction

    // ------------------------------------------------------------------
    // Read path, stage 0: the index goes straight to the BRAM
    // ------------------------------------------------------------------
    assign pal_rd_addr_o = pix_index_i;
    assign pal_rd_en_o   = reset_ni;

    // ------------------------------------------------------------------
    // Stage 1: strobes held while the BRAM read is in flight
    // ------------------------------------------------------------------
    logic        vld_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic        use_border_p1;
    logic [15:0] border_colour;

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            vld_p1 <= visible_i;
            hs_p1  <= hsync_i;
            vs_p1  <= vsync_i;
        end
    end

`ifdef PAL_BORDER_EN
    logic        bord_p1;
    logic [15:0] border_q;

    always_ff @(posedge clk) begin
        if (!reset_ni)
            bord_p1 <= 1'b0;
        else
            bord_p1 <= border_i;
    end

    // The border register is loaded on the same clock edge as the BRAM
    // write of entry 0xFF, so both copies change together.
    always_ff @(posedge clk) begin
        if (!reset_ni)
            border_q <= 16'h0000;
        else if (pal_wr_en_o && (pal_wr_addr_o == 8'hFF))
            border_q <= pal_wr_data_o;
    end

    assign use_border_p1 = bord_p1;
    assign border_colour = border_q;
`else
    logic unused_border;
    assign unused_border = border_i;
    assign use_border_p1 = 1'b0;
    assign border_colour = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Stage 2: registered colour and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            red_o     <= 4'h0;
            green_o   <= 4'h0;
            blue_o    <= 4'h0;
            hsync_o   <= 1'b0;
            vsync_o   <= 1'b0;
            visible_o <= 1'b0;
        end else begin
            {red_o, green_o, blue_o} <= pick_rgb(vld_p1, use_border_p1,
                                                 pal_rd_data_i, border_colour);
            hsync_o   <= hs_p1;
            vsync_o   <= vs_p1;
            visible_o <= vld_p1;
        end
    end

    // ------------------------------------------------------------------
    // Write path: host FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_addr [FIFO_DEPTH];
    logic [15:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only. A pop in the same clock
    // frees a slot, but the host sees that slot only on the next clock.
    assign host_wr_ready_o = (count != FULL_CNT);
    assign fifo_empty_o    = (count == '0);
    assign push = host_wr_valid_i && host_wr_ready_o;
    assign pop  = (count != '0) && (!visible_i || (WRITE_ANYTIME != 0));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_wr_addr_i;
            fifo_data[wr_ptr] <= host_wr_data_i;
        end
    end

    // FIFO_DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Commit stage: one registered BRAM write per popped entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            pal_wr_en_o   <= 1'b0;
            pal_wr_addr_o <= 8'h00;
            pal_wr_data_o <= 16'h0000;
        end else begin
            pal_wr_en_o <= pop;
            if (pop) begin
                pal_wr_addr_o <= fifo_addr[rd_ptr];
                pal_wr_data_o <= fifo_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_palette_pixel_out.sv
// -----------------------------------------------------------------------------
// Testbench for palette_pixel_out.
//
// The driver issues one stimulus step per clock. For each step it works out,
// from a behavioural model, what the DUT should produce:
//   - a pixel entry, due one clock after its input edge
//   - a FIFO status entry for that edge
//   - a palette write entry, when an entry is committed at that edge
// The model uses a queue for the host FIFO and an array for the palette.
// A separate monitor samples on the falling edge and pops and compares every
// entry that has come due. The bench also holds a simple BRAM model with
// read-before-write behaviour.
// -----------------------------------------------------------------------------
module tb_palette_pixel_out;

    localparam int FIFO_DEPTH    = 4;
    localparam int WRITE_ANYTIME = 0;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [7:0]  pix_index_i;
    logic        visible_i;
    logic        hsync_i;
    logic        vsync_i;
    logic        border_i;
    logic        pal_rd_en_o;
    logic [7:0]  pal_rd_addr_o;
    logic [15:0] pal_rd_data_i;
    logic        pal_wr_en_o;
    logic [7:0]  pal_wr_addr_o;
    logic [15:0] pal_wr_data_o;
    logic        host_wr_valid_i;
    logic        host_wr_ready_o;
    logic [7:0]  host_wr_addr_i;
    logic [15:0] host_wr_data_i;
    logic        fifo_empty_o;
    logic [3:0]  red_o;
    logic [3:0]  green_o;
    logic [3:0]  blue_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        visible_o;

    always #5 clk = ~clk;

    palette_pixel_out #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .WRITE_ANYTIME(WRITE_ANYTIME)
    ) dut (
        .clk            (clk),
        .reset_ni       (reset_ni),
        .pix_index_i    (pix_index_i),
        .visible_i      (visible_i),
        .hsync_i        (hsync_i),
        .vsync_i        (vsync_i),
        .border_i       (border_i),
        .pal_rd_en_o    (pal_rd_en_o),
        .pal_rd_addr_o  (pal_rd_addr_o),
        .pal_rd_data_i  (pal_rd_data_i),
        .pal_wr_en_o    (pal_wr_en_o),
        .pal_wr_addr_o  (pal_wr_addr_o),
        .pal_wr_data_o  (pal_wr_data_o),
        .host_wr_valid_i(host_wr_valid_i),
        .host_wr_ready_o(host_wr_ready_o),
        .host_wr_addr_i (host_wr_addr_i),
        .host_wr_data_i (host_wr_data_i),
        .fifo_empty_o   (fifo_empty_o),
        .red_o          (red_o),
        .green_o        (green_o),
        .blue_o         (blue_o),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .visible_o      (visible_o)
    );

    // Edge counter: after the k-th rising edge, cyc == k.
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        if (i == 5)
            return 16'h0A0A;
        return 16'((i * 40503) ^ 23130);
    endfunction

    // BRAM model: one-clock read latency, read-before-write.
    logic [15:0] bram [256];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_val(i);
        end else begin
            if (pal_rd_en_o) pal_rd_data_i <= bram[pal_rd_addr_o];
            if (pal_wr_en_o) bram[pal_wr_addr_o] <= pal_wr_data_o;
        end
    end

    typedef struct packed { int due; logic [3:0] r; logic [3:0] g; logic [3:0] b;
                            logic vis; logic hs; logic vs; } pix_t;
    typedef struct packed { int due; logic [7:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { int due; logic rdy; logic emp; } st_t;
    typedef struct packed { int at; logic [7:0] addr; logic [15:0] data; } sch_t;
    typedef struct packed { logic [7:0] addr; logic [15:0] data; } ent_t;

    pix_t pix_q[$];
    wr_t  wr_q[$];
    st_t  st_q[$];
    sch_t pal_sched[$];
    sch_t bord_sched[$];
    ent_t ref_q[$];
    logic [15:0] ref_pal [256];
    logic [15:0] ref_border;

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One stimulus step, and the model's prediction for the edge it feeds.
    task automatic step(input logic rn, input logic [7:0] idx, input logic vis,
                        input logic hs, input logic vs, input logic bd,
                        input logic hv, input logic [7:0] ha, input logic [15:0] hd);
        int e;
        int sz;
        pix_t p;
        wr_t w;
        st_t s;
        sch_t sc;
        ent_t en;
        logic [15:0] colour;
        e = cyc + 1;
        reset_ni = rn; pix_index_i = idx; visible_i = vis;
        hsync_i = hs; vsync_i = vs; border_i = bd;
        host_wr_valid_i = hv; host_wr_addr_i = ha; host_wr_data_i = hd;
        p = '0;
        p.due = e + 1;
        if (!rn) begin
            // Reset at this edge also wipes the pixel that was still in flight.
            if (pix_q.size() > 0 && pix_q[$].due == e) begin
                pix_t q;
                q = pix_q.pop_back();
                q.r = 0; q.g = 0; q.b = 0; q.vis = 0; q.hs = 0; q.vs = 0;
                pix_q.push_back(q);
            end
            ref_q.delete();
            bord_sched.delete();
            ref_border = 16'h0000;
            pix_q.push_back(p);
            s.due = e; s.rdy = 1'b1; s.emp = 1'b1;
            st_q.push_back(s);
        end else begin
            // A commit popped at edge M reaches palette reads from edge M+2
            // and border pixels from edge M+1.
            while (pal_sched.size() > 0 && pal_sched[0].at <= e - 2) begin
                sc = pal_sched.pop_front();
                ref_pal[sc.addr] = sc.data;
            end
            while (bord_sched.size() > 0 && bord_sched[0].at <= e - 1) begin
                sc = bord_sched.pop_front();
                ref_border = sc.data;
            end
            p.vis = vis; p.hs = hs; p.vs = vs;
            if (vis) begin
                colour = ref_pal[idx];
`ifdef PAL_BORDER_EN
                if (bd) colour = ref_border;
`endif
                p.r = colour[11:8]; p.g = colour[7:4]; p.b = colour[3:0];
            end
            pix_q.push_back(p);

            sz = ref_q.size();
            if (sz > 0 && (!vis || WRITE_ANYTIME != 0)) begin
                en = ref_q.pop_front();
                w.due = e; w.addr = en.addr; w.data = en.data;
                wr_q.push_back(w);
                sc.at = e; sc.addr = en.addr; sc.data = en.data;
                pal_sched.push_back(sc);
`ifdef PAL_BORDER_EN
                if (en.addr == 8'hFF) bord_sched.push_back(sc);
`endif
            end
            if (hv && sz < FIFO_DEPTH) begin
                en.addr = ha; en.data = hd;
                ref_q.push_back(en);
            end
            s.due = e;
            s.rdy = (ref_q.size() != FIFO_DEPTH);
            s.emp = (ref_q.size() == 0);
            st_q.push_back(s);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation that has come due.
    always @(negedge clk) begin : monitor
        pix_t p;
        wr_t  w;
        st_t  s;
        check("rd_en", 32'(pal_rd_en_o), 32'(reset_ni));
        check("rd_addr", 32'(pal_rd_addr_o), 32'(pix_index_i));
        while (st_q.size() > 0 && st_q[0].due <= cyc) begin
            s = st_q.pop_front();
            check("wr_ready", 32'(host_wr_ready_o), 32'(s.rdy));
            check("fifo_empty", 32'(fifo_empty_o), 32'(s.emp));
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            p = pix_q.pop_front();
            check("red", 32'(red_o), 32'(p.r));
            check("green", 32'(green_o), 32'(p.g));
            check("blue", 32'(blue_o), 32'(p.b));
            check("visible_o", 32'(visible_o), 32'(p.vis));
            check("hsync_o", 32'(hsync_o), 32'(p.hs));
            check("vsync_o", 32'(vsync_o), 32'(p.vs));
        end
        if (pal_wr_en_o === 1'b1) begin
            if (wr_q.size() == 0 || wr_q[0].due != cyc) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: pal_wr_en_o=1 addr %0h, required 0 (cycle %0d)",
                         pal_wr_addr_o, cyc);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(pal_wr_addr_o), 32'(w.addr));
                check("wr_data", 32'(pal_wr_data_o), 32'(w.data));
            end
        end
        while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
            w = wr_q.pop_front();
            total++;
            bad++;
            $display("FAIL wr_missed: pal_wr_en_o=0, required 1 for addr %0h data %0h (cycle %0d)",
                     w.addr, w.data, cyc);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset_ni = 1'b0; pix_index_i = '0; visible_i = 0; hsync_i = 0; vsync_i = 0;
        border_i = 0; host_wr_valid_i = 0; host_wr_addr_i = '0; host_wr_data_i = '0;
        for (int i = 0; i < 256; i++) ref_pal[i] = init_val(i);
        ref_border = 16'h0000;

        // Reset held for 3 clocks, then released.
        repeat (3) step(0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 16'd0);

        // Palette lookup of entry 5 with an hsync pulse, then blanking.
        step(1, 8'd5, 1, 0, 0, 0, 0, 8'd0, 16'd0);
        step(1, 8'd5, 1, 1, 0, 0, 0, 8'd0, 16'd0);
        step(1, 8'd5, 1, 0, 1, 0, 0, 8'd0, 16'd0);
        repeat (2) step(1, 8'd5, 0, 0, 0, 0, 0, 8'd0, 16'd0);

        // While visible: fill the FIFO, then try one more push, which is dropped.
        for (int i = 0; i < 5; i++)
            step(1, 8'(10 + i), 1, 0, 0, 0, 1, 8'(8'h20 + i), 16'(16'h0111 * (i + 1)));
        repeat (3) step(1, 8'd5, 1, 0, 0, 0, 0, 8'd0, 16'd0);
        repeat (6) step(1, 8'd5, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 1, 0, 0, 0, 0, 8'd0, 16'd0);

        // Two entries pending, then a push and a pop in the same clock.
        step(1, 8'd1, 1, 0, 0, 0, 1, 8'h30, 16'h0ABC);
        step(1, 8'd2, 1, 0, 0, 0, 1, 8'h31, 16'h0DEF);
        step(1, 8'd3, 0, 0, 0, 0, 1, 8'h32, 16'h0123);
        repeat (4) step(1, 8'h30, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 1, 0, 0, 0, 0, 8'd0, 16'd0);

        // Reset while three writes are pending: they must be discarded.
        for (int i = 0; i < 3; i++) step(1, 8'd7, 1, 0, 0, 0, 1, 8'(8'h40 + i), 16'h0777);
        repeat (2) step(1, 8'd7, 1, 0, 0, 0, 0, 8'd0, 16'd0);
        repeat (2) step(0, 8'd7, 1, 0, 0, 0, 0, 8'd0, 16'd0);
        repeat (4) step(1, 8'h40, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 1, 0, 0, 0, 0, 8'd0, 16'd0);

        // Border colour through palette entry 0xFF.
        step(1, 8'd7, 0, 0, 0, 0, 1, 8'hFF, 16'h0F00);
        repeat (3) step(1, 8'd7, 0, 0, 0, 0, 0, 8'd0, 16'd0);
        repeat (3) step(1, 8'd7, 1, 0, 0, 1, 0, 8'd0, 16'd0);
        repeat (2) step(1, 8'd7, 1, 0, 0, 0, 0, 8'd0, 16'd0);
        step(1, 8'hFF, 1, 0, 0, 0, 0, 8'd0, 16'd0);

        // Random lines: visible runs, blank gaps, random host writes.
        for (int line = 0; line < 120; line++) begin
            int vlen;
            int blen;
            vlen = $urandom_range(4, 20);
            blen = $urandom_range(1, 6);
            for (int j = 0; j < vlen + blen; j++)
                step(1, 8'($urandom), (j < vlen), (j == vlen),
                     ((line % 10) == 0) && (j >= vlen), 1'($urandom),
                     ($urandom_range(0, 9) < 4),
                     (($urandom % 8) == 0) ? 8'hFF : 8'($urandom), 16'($urandom));
        end

        // Drain and settle.
        repeat (12) step(1, 8'($urandom), 0, 0, 0, 0, 0, 8'd0, 16'd0);
        check("fifo_empty_end", 32'(fifo_empty_o), 32'd1);
        check("writes_seen", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
